// File: rtl/count_capture.sv
// -----------------------------------------------------------------------------
// count_capture
//
// Timestamp capture unit fed by a free-running counter. Each synchronized
// rising edge of the asynchronous evt_in line pushes the current cnt value
// into a small first-word-fall-through FIFO, drained over valid/ready.
// Captures that arrive while the FIFO is full (and not being popped on the
// same edge) are dropped and set a sticky overflow flag.
//
// Ports
//   clk       system clock, shared with the counter
//   rst       asynchronous, active-high reset
//   cnt       free-running count, synchronous to clk
//   evt_in    asynchronous event line; rising edge requests a capture
//   ts_data   head-of-FIFO timestamp (0 while the FIFO is empty)
//   ts_valid  FIFO not empty
//   ts_ready  consumer accepts the head entry
//   level     FIFO occupancy, 0..DEPTH
//   overflow  sticky; at least one capture was dropped
//   clr_ovf   synchronous clear of overflow (a same-edge drop wins)
// -----------------------------------------------------------------------------
module count_capture #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         cnt,
    input  logic                     evt_in,
    output logic [WIDTH-1:0]         ts_data,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("count_capture: DEPTH must be a power of 2 and at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_sync_chk
        $error("count_capture: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   evt_edge;

    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [WIDTH-1:0]       mem [DEPTH];

    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // ---- synchronizer and edge history ----
    // Everything resets to 1 so a line already high at reset release is
    // treated as "no edge seen"; a fresh low-to-high transition is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], evt_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign evt_edge = sync[SYNC_STAGES-1] & ~prev;

    // ---- FIFO control ----
    // A pop on the same edge frees the slot, so a capture into a full FIFO
    // is still accepted when the consumer is reading.
    assign level    = wr_ptr - rd_ptr;
    assign ts_valid = (level != '0);
    assign full     = (level == FULL_LVL);
    assign pop      = ts_valid & ts_ready;
    assign push     = evt_edge & (~full | pop);
    assign drop     = evt_edge & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // ---- timestamp storage ----
    // When full with a simultaneous pop, the write slot equals the read slot;
    // the head is read combinationally this cycle before being overwritten.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= cnt;
        end
    end

    // Gating on ts_valid gives a defined 0 out of reset and when empty.
    assign ts_data = ts_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_count_capture.sv
module tb_count_capture;

    logic        clk;
    logic        rst;
    logic [31:0] cnt;
    logic        evt_in;
    logic [31:0] ts_data;
    logic        ts_valid;
    logic        ts_ready;
    logic [2:0]  level;
    logic        overflow;
    logic        clr_ovf;

    logic        ld;
    logic [31:0] ld_val;

    int checks   = 0;
    int failures = 0;
    int e        = 0;

    count_capture #(.WIDTH(32), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .evt_in   (evt_in),
        .ts_data  (ts_data),
        .ts_valid (ts_valid),
        .ts_ready (ts_ready),
        .level    (level),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench counter: 0 after reset, +1 per edge, optionally loaded.
    always @(posedge clk or posedge rst) begin
        if (rst)      cnt <= 32'd0;
        else if (ld)  cnt <= ld_val;
        else          cnt <= cnt + 32'd1;
    end

    typedef struct {
        logic        evt;
        logic        rdy;
        logic        clr;
        int          n;
        logic        exp_valid;
        int          exp_level;
        logic        exp_ovf;
        logic        chk_d;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl [18];

    task automatic step();
        @(posedge clk);
        #1;
        e = e + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic do_reset(input logic evt_level);
        rst      = 1'b1;
        evt_in   = evt_level;
        ts_ready = 1'b0;
        clr_ovf  = 1'b0;
        ld       = 1'b0;
        ld_val   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        e   = 0;
    endtask

    // Idle 4 edges, then n events each 2 high + 2 low; event raised at edge E
    // is pushed at edge E+3 with timestamp E+2.
    task automatic fire_events(input int n);
        repeat (4) step();
        for (int i = 0; i < n; i++) begin
            evt_in = 1'b1;
            repeat (2) step();
            evt_in = 1'b0;
            repeat (2) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pop [4];

        // Fill/overflow sequence, edges counted from reset release.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 4, 1'b0, 0, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 1, 1'b0, 1'b1, 32'd6};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1, 1'b0, 1'b1, 32'd6};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 2, 1'b0, 1'b1, 32'd6};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 2, 1'b0, 1'b1, 32'd6};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 3, 1'b0, 1'b1, 32'd6};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 3, 1'b0, 1'b1, 32'd6};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 4, 1'b0, 1'b1, 32'd6};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 4, 1'b0, 1'b1, 32'd6};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 4, 1'b1, 1'b1, 32'd6};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 4, 1'b1, 1'b1, 32'd6};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 3, 1'b1, 1'b1, 32'd10};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 2, 1'b1, 1'b1, 32'd14};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1, 1'b1, 1'b1, 32'd18};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 0, 1'b1, 1'b0, 32'd0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 32'd0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0, 32'd0};

        rst = 1'b1;
        evt_in = 1'b0; ts_ready = 1'b0; clr_ovf = 1'b0; ld = 1'b0; ld_val = 32'd0;

        // ---- single event ----
        do_reset(1'b0);
        chk("rst_valid",    32'(ts_valid), 32'd0);
        chk("rst_level",    32'(level),    32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_data",     ts_data,       32'd0);
        repeat (19) step();
        evt_in = 1'b1;
        repeat (2) step();
        chk("single_valid_e21", 32'(ts_valid), 32'd0);
        step();
        chk("single_valid_e22", 32'(ts_valid), 32'd1);
        chk("single_data",      ts_data,       32'd21);
        chk("single_level",     32'(level),    32'd1);
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        chk("single_pop_valid", 32'(ts_valid), 32'd0);
        chk("single_pop_level", 32'(level),    32'd0);
        repeat (3) step();
        chk("single_held_no_recapture", 32'(ts_valid), 32'd0);

        // ---- fill, overflow, drain, clear (table-driven) ----
        do_reset(1'b0);
        for (int i = 0; i < 18; i++) begin
            evt_in   = tbl[i].evt;
            ts_ready = tbl[i].rdy;
            clr_ovf  = tbl[i].clr;
            repeat (tbl[i].n) step();
            chk($sformatf("tbl%0d_valid", i),    32'(ts_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_level", i),    32'(level),    32'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].exp_ovf));
            if (tbl[i].chk_d) chk($sformatf("tbl%0d_data", i), ts_data, tbl[i].exp_d);
        end
        ts_ready = 1'b0;
        clr_ovf  = 1'b0;

        // ---- push and pop on the same edge while full ----
        do_reset(1'b0);
        fire_events(4);
        chk("pp_full_level", 32'(level), 32'd4);
        evt_in = 1'b1;
        repeat (2) step();
        evt_in   = 1'b0;
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        chk("pp_level",    32'(level),    32'd4);
        chk("pp_overflow", 32'(overflow), 32'd0);
        exp_pop[0] = 32'd10; exp_pop[1] = 32'd14; exp_pop[2] = 32'd18; exp_pop[3] = 32'd22;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_pop%0d_data", i), ts_data, exp_pop[i]);
            ts_ready = 1'b1;
            step();
            ts_ready = 1'b0;
        end
        chk("pp_drained_valid", 32'(ts_valid), 32'd0);

        // ---- clear coincident with a drop ----
        do_reset(1'b0);
        fire_events(4);
        evt_in = 1'b1;
        repeat (2) step();
        evt_in = 1'b0;
        chk("clrdrop_pre_ovf", 32'(overflow), 32'd0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clrdrop_ovf",   32'(overflow), 32'd1);
        chk("clrdrop_level", 32'(level),    32'd4);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf_after", 32'(overflow), 32'd0);

        // ---- count wrap ----
        do_reset(1'b0);
        repeat (5) step();
        ld = 1'b1; ld_val = 32'hFFFF_FFFE; evt_in = 1'b1;
        step();
        ld = 1'b0; evt_in = 1'b0;
        repeat (2) step();
        evt_in = 1'b1;
        step();
        evt_in = 1'b0;
        repeat (3) step();
        chk("wrap_level", 32'(level), 32'd2);
        chk("wrap_ts0",   ts_data,    32'hFFFF_FFFF);
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        chk("wrap_ts1",   ts_data,    32'h0000_0002);
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        chk("wrap_empty", 32'(ts_valid), 32'd0);

        // ---- evt_in held high across reset release ----
        do_reset(1'b1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("rstA_valid_c%0d", i), 32'(ts_valid), 32'd0);
        end
        evt_in = 1'b0;

        // ---- asynchronous reset with entries queued ----
        do_reset(1'b0);
        fire_events(3);
        chk("rstB_pre_level", 32'(level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("rstB_level", 32'(level),    32'd0);
        chk("rstB_valid", 32'(ts_valid), 32'd0);
        chk("rstB_data",  ts_data,       32'd0);
        do_reset(1'b0);
        repeat (4) step();
        chk("rstB_after_level", 32'(level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_capture.md
Name: count_capture

Overview:
- Timestamp capture unit that sits directly downstream of the 32-bit free-running counter and consumes its `cnt` output.
- On each rising edge of an asynchronous external event line, it latches the current count into a small FIFO.
- Software or a downstream block drains the FIFO over a valid/ready interface.
- A sticky overflow flag records any events dropped while the FIFO was full.

Parameters:
- WIDTH, 32, width of the count and of the timestamp.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- SYNC_STAGES, 2, flops in the evt_in synchronizer; must be at least 2.

Ports:
- clk  in  1  system clock, shared with the counter.
- rst  in  1  asynchronous, active-high reset.
- cnt  in  WIDTH  free-running count from the counter, synchronous to clk.
- evt_in  in  1  asynchronous event line; a rising edge requests a capture.
- ts_data  out  WIDTH  head-of-FIFO timestamp; meaningful only while ts_valid=1.
- ts_valid  out  1  FIFO not empty.
- ts_ready  in  1  consumer accepts the head entry.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky; an event was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - All synchronizer flops and the edge-detect history flop reset to 1. An evt_in held high through reset release therefore produces no capture.
  - Read and write pointers, level, ts_valid, and overflow reset to 0.
  - ts_data resets to 0.
- Edge detect:
  - Define sync_out as the last synchronizer stage and prev as the registered copy of sync_out.
  - The edge is asserted combinationally when sync_out=1 and prev=0.
  - It is active for exactly one cycle per synchronized rising edge.
- Capture:
  - On the clk edge where the edge is asserted, push the cnt value present on that edge.
  - Latency: evt_in first sampled high at edge k leads to the push at edge k+SYNC_STAGES. ts_valid is high after that edge if the FIFO was empty.
  - Total: SYNC_STAGES+1 edges from first sample to visibility.
  - There is no empty-FIFO bypass.
- Event timing:
  - Events closer together than one low synchronized cycle merge into a single capture.
  - An evt_in pulse shorter than one clk period may be missed. This is documented and not an error.
- FIFO:
  - First-word fall-through: ts_data always shows the oldest entry.
  - Pop occurs when ts_valid and ts_ready are both 1 on a clk edge.
  - While ts_valid=0, ts_ready is ignored.
  - Pointers are $clog2(DEPTH)+1 bits wide, with a wrap bit for full/empty discrimination. Pointers wrap modulo 2·DEPTH.
  - level = wr_ptr − rd_ptr.
- Push and pop in the same cycle:
  - If not full: both occur; level is unchanged. If the FIFO holds exactly one entry, ts_valid stays 1 and ts_data shows the new entry.
  - If full (level=DEPTH): pop frees a slot and the push is accepted; level stays DEPTH; overflow is not set.
- Push when full with no pop: the capture is dropped and overflow is set to 1 on that edge.
- overflow behaviour:
  - It stays 1 until clr_ovf=1 on an edge.
  - If clr_ovf and a drop occur on the same edge, the set wins and overflow stays 1.
- Count wrap-around: timestamps are raw cnt values. No wrap compensation is applied; the consumer handles modular differences.
- Reset mid-operation: all queued timestamps are discarded and outputs return to reset values immediately (asynchronously). The next capture requires a fresh synchronized rising edge after release.

Test Plan:
- Single event:
  - Stimulus: bench counter starts at 0 after reset and increments each clk. Raise evt_in before edge 20 and hold high.
  - Response: ts_valid rises after edge 22; ts_data = cnt value at edge 22; level=1. Hold ts_ready=1 for one edge → ts_valid=0, level=0.
- Fill and overflow (DEPTH=4):
  - Stimulus: issue 5 separated events with ts_ready=0.
  - Response: level=4; 5th event dropped and overflow=1; ts_data still equals the 1st timestamp. Pop all 4 → values in capture order. Pulse clr_ovf → overflow=0.
- Push and pop when full:
  - Stimulus: with level=4, hold ts_ready=1 on the edge where a capture occurs.
  - Response: level stays 4; overflow stays 0; newest entry is the last of the 4 read back.
- Reset behaviour:
  - Stimulus A: hold evt_in=1 across reset release. Response A: no capture; ts_valid=0 for 10+ cycles.
  - Stimulus B: assert rst with level=3. Response B: level=0 and ts_valid=0 immediately, without waiting for a clk edge.
- Wrap and priority:
  - Stimulus: force cnt=32'hFFFF_FFFE, fire two events 3 cycles apart.
  - Response: timestamps read back are the raw values across wrap, e.g. FFFF_FFFE+… then 0000_0001.
  - Also verify clr_ovf coincident with a drop leaves overflow=1.
